// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider: 5-bit dividend / 4-bit divisor, one quotient bit per cycle.
// Each trial subtraction runs on a ripple-borrow chain of full-adder cells (R' + ~D + 1).
module seq_restoring_divider (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [4:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [4:0] quotient,
  output logic [3:0] remainder,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state, state_nx;
  logic [4:0] q, q_nx, r, r_nx;
  logic [3:0] d, d_nx;
  logic [2:0] cnt, cnt_nx;
  logic [4:0] quo_nx;
  logic [3:0] rem_nx;
  logic       dbz_nx;

  // Trial subtraction: carry-out high means no borrow, so R' >= D.
  logic [4:0] r_sh, sub_b, t;
  logic [5:0] c;

  assign r_sh  = {r[3:0], q[4]};
  assign sub_b = ~{1'b0, d};
  assign c[0]  = 1'b1;

  genvar i;
  generate
    for (i = 0; i < 5; i++) begin : g_fa
      assign t[i]   = r_sh[i] ^ sub_b[i] ^ c[i];
      assign c[i+1] = (r_sh[i] & sub_b[i]) | (c[i] & (r_sh[i] ^ sub_b[i]));
    end
  endgenerate

  always_comb begin
    state_nx = state;
    q_nx     = q;
    r_nx     = r;
    d_nx     = d;
    cnt_nx   = cnt;
    quo_nx   = quotient;
    rem_nx   = remainder;
    dbz_nx   = div_by_zero;
    case (state)
      IDLE: begin
        if (start) begin
          if (divisor != 4'd0) begin
            q_nx     = dividend;
            r_nx     = 5'd0;
            d_nx     = divisor;
            cnt_nx   = 3'd0;
            state_nx = RUN;
          end else begin
            quo_nx   = 5'b11111;
            rem_nx   = 4'b0000;
            dbz_nx   = 1'b1;
            state_nx = DONE;
          end
        end
      end
      RUN: begin
        q_nx   = {q[3:0], c[5]};
        r_nx   = c[5] ? t : r_sh;
        cnt_nx = cnt + 3'd1;
        if (cnt == 3'd4) begin
          quo_nx   = q_nx;
          rem_nx   = r_nx[3:0];
          dbz_nx   = 1'b0;
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // busy/done are registered from the next state so outputs come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      q           <= 5'd0;
      r           <= 5'd0;
      d           <= 4'd0;
      cnt         <= 3'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= 5'd0;
      remainder   <= 4'd0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_nx;
      q           <= q_nx;
      r           <= r_nx;
      d           <= d_nx;
      cnt         <= cnt_nx;
      busy        <= (state_nx != IDLE);
      done        <= (state_nx == DONE);
      quotient    <= quo_nx;
      remainder   <= rem_nx;
      div_by_zero <= dbz_nx;
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider against a plain-arithmetic reference (a/b, a%b).
module tb_seq_restoring_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [4:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       busy, done, div_by_zero;
  logic [4:0] quotient;
  logic [3:0] remainder;

  int checks = 0;
  int errors = 0;

  seq_restoring_divider dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic void ref_div(input int a, input int b, output int q, output int r, output int z);
    if (b == 0) begin q = 31; r = 0; z = 1; end
    else begin q = a / b; r = a % b; z = 0; end
  endfunction

  // Issues one request from IDLE (called #1 after an edge) and follows it back to IDLE.
  // lat = edges after acceptance before done is seen; -1 if it never shows.
  task automatic issue_div(input int a, input int b, output int q, output int r, output int z,
                           output int lat, output int bcyc, output int dones);
    q = -1; r = -1; z = -1; lat = -1; bcyc = 0; dones = 0;
    dividend = 5'(a); divisor = 4'(b); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = 5'($urandom); divisor = 4'($urandom);
    for (int k = 0; k < 20; k++) begin
      if (busy) bcyc++;
      if (done) begin
        dones++;
        if (lat < 0) begin lat = k; q = int'(quotient); r = int'(remainder); z = int'(div_by_zero); end
      end
      if (lat >= 0 && !busy && !done) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 12'd0) begin
      errors++;
      $display("FAIL reset_state got b=%b d=%b q=%0d r=%0d z=%b want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int q, r, z, lat, bcyc, dones;
    issue_div(29, 4, q, r, z, lat, bcyc, dones);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL basic_latency got %0d want 5", lat); end
    checks++;
    if (q !== 7 || r !== 1 || z !== 0) begin
      errors++; $display("FAIL basic_result got q=%0d r=%0d z=%0d want q=7 r=1 z=0", q, r, z);
    end
    checks++;
    if (bcyc !== 6) begin errors++; $display("FAIL basic_busy_cycles got %0d want 6", bcyc); end
    checks++;
    if (dones !== 1) begin errors++; $display("FAIL basic_done_pulses got %0d want 1", dones); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (quotient !== 5'd7 || remainder !== 4'd1) begin
      errors++; $display("FAIL basic_hold got q=%0d r=%0d want q=7 r=1", quotient, remainder);
    end
  endtask

  task automatic test_edges;
    int tab_a[4] = '{31, 5, 0, 31};
    int tab_b[4] = '{1, 7, 3, 15};
    int q, r, z, lat, bcyc, dones, eq, er, ez;
    for (int i = 0; i < 4; i++) begin
      issue_div(tab_a[i], tab_b[i], q, r, z, lat, bcyc, dones);
      ref_div(tab_a[i], tab_b[i], eq, er, ez);
      checks++;
      if (q !== eq || r !== er || z !== ez || lat !== 5) begin
        errors++;
        $display("FAIL edge_%0d_%0d got q=%0d r=%0d z=%0d lat=%0d want q=%0d r=%0d z=%0d lat=5",
                 tab_a[i], tab_b[i], q, r, z, lat, eq, er, ez);
      end
    end
  endtask

  task automatic test_div_zero;
    int q, r, z, lat, bcyc, dones;
    issue_div(12, 0, q, r, z, lat, bcyc, dones);
    checks++;
    if (lat !== 0 || bcyc !== 1 || dones !== 1) begin
      errors++; $display("FAIL dbz_timing got lat=%0d busy=%0d dones=%0d want 0 1 1", lat, bcyc, dones);
    end
    checks++;
    if (q !== 31 || r !== 0 || z !== 1) begin
      errors++; $display("FAIL dbz_result got q=%0d r=%0d z=%0d want q=31 r=0 z=1", q, r, z);
    end
    issue_div(12, 5, q, r, z, lat, bcyc, dones);
    checks++;
    if (q !== 2 || r !== 2 || z !== 0 || lat !== 5) begin
      errors++; $display("FAIL dbz_followup got q=%0d r=%0d z=%0d lat=%0d want 2 2 0 5", q, r, z, lat);
    end
  endtask

  task automatic test_ignore_start;
    int waited = -1, dones = 0, q = -1, r = -1;
    dividend = 5'd20; divisor = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    dividend = 5'd9; divisor = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (done) begin waited = k; q = int'(quotient); r = int'(remainder); dones++; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (waited !== 3) begin errors++; $display("FAIL ignore_timing got %0d want 3", waited); end
    dividend = 5'd9; divisor = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ignore_in_done busy got %b want 0", busy); end
    for (int k = 0; k < 8; k++) begin
      if (done) dones++;
      @(posedge clk); #1;
    end
    checks++;
    if (q !== 6 || r !== 2 || dones !== 1) begin
      errors++; $display("FAIL ignore_result got q=%0d r=%0d dones=%0d want 6 2 1", q, r, dones);
    end
  endtask

  task automatic test_async_reset;
    int q, r, z, lat, bcyc, dones = 0;
    dividend = 5'd27; divisor = 4'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 12'd0) begin
      errors++;
      $display("FAIL async_reset got b=%b d=%b q=%0d r=%0d z=%b want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL reset_abort activity got %0d want 0", dones); end
    issue_div(27, 5, q, r, z, lat, bcyc, dones);
    checks++;
    if (q !== 5 || r !== 2 || z !== 0 || lat !== 5) begin
      errors++; $display("FAIL after_reset got q=%0d r=%0d z=%0d lat=%0d want 5 2 0 5", q, r, z, lat);
    end
  endtask

  // Full sweep of nonzero divisors in shuffled order, each request at the earliest accepting edge.
  task automatic test_back_to_back;
    int pairs[$];
    int q, r, z, lat, bcyc, dones, eq, er, ez, a, b, j, tmp;
    for (int x = 0; x < 32; x++)
      for (int y = 1; y < 16; y++) pairs.push_back(x * 16 + y);
    for (int i = pairs.size() - 1; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = pairs[i]; pairs[i] = pairs[j]; pairs[j] = tmp;
    end
    foreach (pairs[i]) begin
      a = pairs[i] / 16; b = pairs[i] % 16;
      issue_div(a, b, q, r, z, lat, bcyc, dones);
      ref_div(a, b, eq, er, ez);
      checks++;
      if (q !== eq || r !== er || z !== ez || lat !== 5 || bcyc !== 6 || dones !== 1) begin
        errors++;
        $display("FAIL sweep_%0d_%0d got q=%0d r=%0d z=%0d lat=%0d busy=%0d dones=%0d want q=%0d r=%0d z=%0d 5 6 1",
                 a, b, q, r, z, lat, bcyc, dones, eq, er, ez);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_div_zero();
    test_ignore_start();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
